// File: rtl/safecrack_pkg.sv
// Shared types and helpers for the parametrised safecrack lock.
package safecrack_pkg;

  // One-hot controller states. PROG is only reachable when SAFECRACK_PROG_EN is defined.
  typedef enum logic [4:0] {
    ENTRY   = 5'b00001,
    ERROR   = 5'b00010,
    SUCCESS = 5'b00100,
    LOCKOUT = 5'b01000,
    PROG    = 5'b10000
  } state_t;

  // Dwell in ms to clock cycles. 64-bit math: 30 s at 50 MHz overflows 32 bits.
  function automatic longint ms_to_cycles(input longint ms, input longint clk_hz);
    return (ms * clk_hz) / 64'd1000;
  endfunction

  // Thermometer code with the n lowest bits set (n clipped to 32).
  function automatic logic [31:0] thermometer(input int unsigned n);
    logic [31:0] t;
    for (int i = 0; i < 32; i++) t[i] = (i < n);
    return t;
  endfunction

endpackage

// File: rtl/safecrack_lock_param_btn_edge_sync.sv
// Button front end: inverts active-low raw buttons, two-flop synchronises them
// and produces a one-cycle pulse on each press (rising edge of "pressed").
module btn_edge_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;

  // Synchroniser and previous-value register; all reset to "not pressed".
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= ~btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Rise detect: pressed now, not pressed last cycle.
  always_comb edges = sync2_q & ~prev_q;

endmodule

// File: rtl/safecrack_lock_param.sv
// Parametrised combination lock with failure counting and timed lockout.
// Optional build macro SAFECRACK_PROG_EN adds runtime code reprogramming (PROG state).
module safecrack_lock_param
  import safecrack_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int NUM_BTN      = 4,
  parameter int CODE_LEN     = 4,
  localparam int IDX_W       = $clog2(NUM_BTN),
  parameter logic [CODE_LEN*IDX_W-1:0] DEFAULT_CODE = 8'hE4,
  parameter int ERR_TIME_MS  = 3000,
  parameter int OK_TIME_MS   = 5000,
  parameter int LOCK_TIME_MS = 30000,
  parameter int MAX_FAILS    = 3,
  parameter int LED_W        = 8,
  localparam int FC_W        = $clog2(MAX_FAILS + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               prog_req,
  output logic [LED_W-1:0]   leds_green,
  output logic               led_red,
  output logic               locked,
  output logic [FC_W-1:0]    fail_cnt
);

  localparam longint ERR_D  = ms_to_cycles(ERR_TIME_MS, CLK_FREQ_HZ);
  localparam longint OK_D   = ms_to_cycles(OK_TIME_MS, CLK_FREQ_HZ);
  localparam longint LOCK_D = ms_to_cycles(LOCK_TIME_MS, CLK_FREQ_HZ);
  localparam longint D_MAX  = (ERR_D > OK_D) ? ((ERR_D > LOCK_D) ? ERR_D : LOCK_D)
                                             : ((OK_D > LOCK_D) ? OK_D : LOCK_D);
  localparam int TMR_W = (D_MAX > 1) ? $clog2(D_MAX) : 1;
  localparam int IW    = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int CW    = CODE_LEN * IDX_W;

  // Timer loads D-1 so that the state lasts exactly D cycles.
  localparam logic [TMR_W-1:0] ERR_LD  = TMR_W'(ERR_D - 1);
  localparam logic [TMR_W-1:0] OK_LD   = TMR_W'(OK_D - 1);
  localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCK_D - 1);

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [FC_W-1:0]    fail_q, fail_d, fail_inc;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CW-1:0]      code;
  logic [NUM_BTN-1:0] edges;
  logic               one_hot;
  logic [IDX_W-1:0]   p;

`ifdef SAFECRACK_PROG_EN
  logic [IW-1:0]      pidx_q, pidx_d;
  logic [CW-1:0]      shadow_q, shadow_d;
  logic [CW-1:0]      code_q, code_d;
  assign code = code_q;
`else
  logic unused_prog_req;
  assign unused_prog_req = prog_req;
  assign code = DEFAULT_CODE;
`endif

  btn_edge_sync #(.WIDTH(NUM_BTN)) u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .btn   (btn),
    .edges (edges)
  );

  // Press classification: a valid press is exactly one edge; p is its index.
  always_comb begin
    one_hot = $onehot(edges);
    p       = '0;
    for (int i = 0; i < NUM_BTN; i++) if (edges[i]) p = IDX_W'(i);
    fail_inc = (fail_q < FC_W'(MAX_FAILS)) ? fail_q + 1'b1 : fail_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ENTRY;
      idx_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
`ifdef SAFECRACK_PROG_EN
      pidx_q   <= '0;
      shadow_q <= DEFAULT_CODE;
      code_q   <= DEFAULT_CODE;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
`ifdef SAFECRACK_PROG_EN
      pidx_q   <= pidx_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
`endif
    end
  end

  // Next-state logic; edges seen outside ENTRY/PROG are simply dropped.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
`ifdef SAFECRACK_PROG_EN
    pidx_d   = pidx_q;
    shadow_d = shadow_q;
    code_d   = code_q;
`endif
    unique case (state_q)
      ENTRY: begin
        if (edges != '0) begin
          if (one_hot && (p == code[idx_q*IDX_W +: IDX_W])) begin
            if (idx_q < IW'(CODE_LEN - 1)) begin
              idx_d = idx_q + 1'b1;
            end else begin
              state_d = SUCCESS;
              timer_d = OK_LD;
              fail_d  = '0;
              idx_d   = '0;
            end
          end else begin
            idx_d  = '0;
            fail_d = fail_inc;
            if (fail_inc == FC_W'(MAX_FAILS)) begin
              state_d = LOCKOUT;
              timer_d = LOCK_LD;
            end else begin
              state_d = ERROR;
              timer_d = ERR_LD;
            end
          end
        end
      end
      ERROR: begin
        if (timer_q == '0) begin
          state_d = ENTRY;
          idx_d   = '0;
        end else timer_d = timer_q - 1'b1;
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ENTRY;
          idx_d   = '0;
          fail_d  = '0;
        end else timer_d = timer_q - 1'b1;
      end
      SUCCESS: begin
        if (timer_q == '0) begin
          state_d = ENTRY;
          idx_d   = '0;
`ifdef SAFECRACK_PROG_EN
          if (prog_req) begin
            state_d = PROG;
            pidx_d  = '0;
          end
`endif
        end else timer_d = timer_q - 1'b1;
      end
`ifdef SAFECRACK_PROG_EN
      PROG: begin
        if (one_hot) begin
          shadow_d[pidx_q*IDX_W +: IDX_W] = p;
          if (pidx_q == IW'(CODE_LEN - 1)) begin
            code_d  = shadow_d;
            pidx_d  = '0;
            idx_d   = '0;
            state_d = ENTRY;
          end else pidx_d = pidx_q + 1'b1;
        end
      end
`endif
      default: state_d = ENTRY;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    leds_green = '0;
    led_red    = 1'b0;
    locked     = 1'b0;
    fail_cnt   = fail_q;
    unique case (state_q)
      ENTRY:   leds_green = LED_W'(thermometer(32'(idx_q) + 1));
      SUCCESS: leds_green = '1;
      ERROR:   led_red    = 1'b1;
      LOCKOUT: begin
        led_red = 1'b1;
        locked  = 1'b1;
      end
`ifdef SAFECRACK_PROG_EN
      PROG: begin
        leds_green          = LED_W'(thermometer(32'(pidx_q) + 1));
        leds_green[LED_W-1] = 1'b1;
      end
`endif
      default: leds_green = '0;
    endcase
  end

endmodule

// File: tb/tb_safecrack_lock_param.sv
// Directed bench for safecrack_lock_param at 1 kHz (1 ms = 1 cycle).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_safecrack_lock_param;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] btn = 4'hF;
  logic       prog_req = 1'b0;
  logic [7:0] leds_green;
  logic       led_red;
  logic       locked;
  logic [1:0] fail_cnt;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  // Clock.
  always #5 clk = ~clk;

  safecrack_lock_param #(
    .CLK_FREQ_HZ (1000),
    .NUM_BTN     (4),
    .CODE_LEN    (4),
    .DEFAULT_CODE(8'hE4),
    .ERR_TIME_MS (3),
    .OK_TIME_MS  (5),
    .LOCK_TIME_MS(10),
    .MAX_FAILS   (3),
    .LED_W       (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .btn        (btn),
    .prog_req   (prog_req),
    .leds_green (leds_green),
    .led_red    (led_red),
    .locked     (locked),
    .fail_cnt   (fail_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] leds, input logic red,
                            input logic lck, input logic [1:0] fc);
    check({tag, "_leds"}, 32'(leds_green), 32'(leds));
    check({tag, "_red"},  32'(led_red),    32'(red));
    check({tag, "_lock"}, 32'(locked),     32'(lck));
    check({tag, "_fail"}, 32'(fail_cnt),   32'(fc));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press of mask; hold stays low afterwards. Returns at the
  // first sample point after the press has taken effect (edge k+2).
  task automatic press(input logic [3:0] mask, input logic [3:0] hold = 4'h0);
    @(negedge clk) btn = ~mask;
    @(negedge clk) btn = ~hold;
    cycles(2);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    btn = 4'hF;
    prog_req = 1'b0;
    cycles(2);
    check_outs("reset", 8'h01, 1'b0, 1'b0, 2'd0);
    @(negedge clk) rstn = 1'b1;
    cycles(1);
  endtask

  task automatic enter_default();
    exp_q = {8'h03, 8'h07, 8'h0F, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      press(4'(1 << i));
      check("entry_led", 32'(leds_green), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    // Correct code, then exactly 5 cycles of SUCCESS.
    do_reset();
    enter_default();
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      check("ok_dwell", 32'(leds_green), 32'hFF);
    end
    cycles(1);
    check_outs("ok_exit", 8'h01, 1'b0, 1'b0, 2'd0);

    // Wrong second digit: 3 cycles of ERROR.
    press(4'b0001);
    check("t2_led", 32'(leds_green), 32'h03);
    press(4'b0100);
    check_outs("err_first", 8'h00, 1'b1, 1'b0, 2'd1);
    for (int i = 0; i < 2; i++) begin
      cycles(1);
      check("err_dwell", 32'(led_red), 32'd1);
    end
    cycles(1);
    check_outs("err_exit", 8'h01, 1'b0, 1'b0, 2'd1);

    // Three wrong first presses: lockout for 10 cycles, presses ignored.
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      press(4'b0010);
      check_outs("fail_n", 8'h00, 1'b1, 1'b0, 2'(k));
      cycles(3);
      check("fail_back", 32'(leds_green), 32'h01);
    end
    press(4'b0010);
    check_outs("lock_first", 8'h00, 1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 10; i++) begin
      check("lock_dwell", 32'(locked), 32'd1);
      btn = (i == 2) ? 4'b1110 : 4'b1111;
      cycles(1);
    end
    check_outs("lock_exit", 8'h01, 1'b0, 1'b0, 2'd0);
    cycles(4);
    check_outs("lock_quiet", 8'h01, 1'b0, 1'b0, 2'd0);

    // Two buttons at once is wrong; btn1 held across ERROR exit makes no edge.
    do_reset();
    press(4'b0011, 4'b0010);
    check_outs("multi", 8'h00, 1'b1, 1'b0, 2'd1);
    cycles(3);
    check_outs("multi_exit", 8'h01, 1'b0, 1'b0, 2'd1);
    cycles(3);
    check_outs("held", 8'h01, 1'b0, 1'b0, 2'd1);
    btn = 4'hF;
    cycles(3);
    check_outs("released", 8'h01, 1'b0, 1'b0, 2'd1);

    // Asynchronous reset in SUCCESS.
    enter_default();
    check("succ_fail0", 32'(fail_cnt), 32'd0);
    cycles(2);
    rstn = 1'b0;
    #1;
    check_outs("async_rst", 8'h01, 1'b0, 1'b0, 2'd0);
    @(negedge clk) rstn = 1'b1;
    cycles(1);
    enter_default();

`ifdef SAFECRACK_PROG_EN
    // Reprogram to 3,3,0,1 and confirm old code fails, new code opens.
    prog_req = 1'b1;
    cycles(5);
    check("prog_enter", 32'(leds_green), 32'h81);
    prog_req = 1'b0;
    press(4'b1000);
    check("prog_d0", 32'(leds_green), 32'h83);
    press(4'b1000);
    check("prog_d1", 32'(leds_green), 32'h87);
    press(4'b0001);
    check("prog_d2", 32'(leds_green), 32'h8F);
    press(4'b0010);
    check_outs("prog_done", 8'h01, 1'b0, 1'b0, 2'd0);
    press(4'b0001);
    check_outs("old_code", 8'h00, 1'b1, 1'b0, 2'd1);
    cycles(3);
    exp_q = {8'h03, 8'h07, 8'h0F, 8'hFF};
    press(4'b1000);
    check("new_c0", 32'(leds_green), 32'(exp_q.pop_front()));
    press(4'b1000);
    check("new_c1", 32'(leds_green), 32'(exp_q.pop_front()));
    press(4'b0001);
    check("new_c2", 32'(leds_green), 32'(exp_q.pop_front()));
    press(4'b0010);
    check("new_c3", 32'(leds_green), 32'(exp_q.pop_front()));
    check("new_fail0", 32'(fail_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
